uart_rx_top: RTL and testbench
==============================

// Module: uart_rx_top
// PURPOSE
// - 16550-style serial receiver; mirror of the UART transmit path. Recovers 5..8-bit frames from rx.
// - Frame: start bit, data bits LSB first, optional parity bit, stop bit. Timing comes from a 16x oversampling baud_pulse.
// - Sits between the rx pin and the RX FIFO; LSR error flags (PE/FE/BI) are produced per character alongside the push.
// PARAMETERS
// - none (frame format is runtime-configured from LCR fields)
// PORTS
// - clk            in   1  system clock; single clock domain
// - rst            in   1  synchronous, active-high reset
// - baud_pulse     in   1  1-clk enable at 16x baud rate
// - rx             in   1  serial input, async to clk, idle high
// - pen            in   1  parity enable (LCR.PEN)
// - eps            in   1  even parity select (LCR.EPS)
// - sticky_parity  in   1  stick parity (LCR.SP)
// - wls            in   2  word length: 00=5, 01=6, 10=7, 11=8 bits
// - push           out  1  1-clk strobe: character complete, write RX FIFO
// - rx_out         out  8  received data, right-justified; unused MSBs = 0
// - pe             out  1  parity error for rx_out
// - fe             out  1  framing error (stop bit sampled 0)
// - bi             out  1  break: data, parity (if pen) and stop all 0
// BEHAVIOUR
// - Reset (sync, clk edge with rst=1): state=IDLE, push=0, rx_out=0, pe=fe=bi=0, count=0, armed=0.
// - Reset mid-frame: the partial character is discarded and no push is issued.
// - rx sync: 2-flop synchronizer, both flops reset to 1. The FSM uses only rx_s (the 2nd flop).
// - FSM advance: on clk only when baud_pulse=1, except push/flag updates noted below.
// - State IDLE:
//   - armed<=1 when rx_s=1.
//   - If armed and rx_s=0: armed<=0, count<=7, goto START.
// - State START:
//   - count!=0: count--.
//   - count==0 (mid start bit): rx_s=0 -> count<=15, bitcnt<=wls+4, goto DATA.
//   - count==0 and rx_s=1: false start -> goto IDLE, no push.
// - State DATA:
//   - count!=0: count--.
//   - count==0: sample rx_s as the next data bit, count<=15.
//   - After bitcnt+1 bits: goto PARITY if pen=1, else STOP.
// - State PARITY:
//   - count!=0: count--.
//   - count==0: capture pbit, count<=15, goto STOP.
// - State STOP:
//   - count!=0: count--.
//   - count==0 (mid stop bit): update outputs, push<=1, goto IDLE.
//   - Output update: rx_out<=data, pe<=par_err, fe<=~rx_s, bi<=(data==0)&(~pen|pbit==0)&(rx_s==0).
// - Sampling latency:
//   - Start bit sampled 8 pulses after the falling edge is seen.
//   - Each later bit is sampled 16 pulses after the previous sample.
//   - push is high exactly 1 clk, in the cycle after the stop-sample baud_pulse edge; it is cleared on the next clk regardless of baud_pulse.
// - Output hold: rx_out/pe/fe/bi hold until the next push or reset.
// - Parity check (data = the wls-selected bits only):
//   - {sp,eps}=00: pe = ~(^data ^ pbit)  (odd parity)
//   - {sp,eps}=01: pe = ^data ^ pbit     (even parity)
//   - {sp,eps}=10: pe = ~pbit            (expect 1)
//   - {sp,eps}=11: pe = pbit             (expect 0)
//   - pen=0: pe=0.
// - Stop bits: only the first stop bit is checked (stb has no effect on RX).
// - Break handling: after fe/bi, armed=0 until rx_s returns high; a held-low line yields exactly one push.
// - Config changes (wls/pen/eps/sp) mid-frame: undefined result. The bench changes them only in IDLE.
// TESTING
// - T1: 8N1, rx frame 0xA5, 16 baud_pulses/bit -> one push, rx_out=0xA5, pe=fe=bi=0.
// - T2: 7 bits, even parity, send 0x35 with pbit=1 (wrong) -> rx_out=0x35, pe=1; resend with pbit=0 -> pe=0.
// - T3: 5N1 0x1F with stop bit=0 -> rx_out=0x1F, fe=1, bi=0; next frame 0x0A clean -> fe=0.
// - T4: rx held low 3 frame times (8N1) -> exactly one push, rx_out=0x00, fe=1, bi=1. No new frame until rx high, then 0x55 is received OK.
// - T5: rx low pulse of 5 baud_pulses, then high -> no push, FSM back in IDLE; following frame 0xC3 is received correctly.
// - T6: rst=1 during DATA bit 3 of 0xFF -> no push, all outputs 0; next frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial input, baud enable, LCR frame format and per-character RX FIFO push with LSR flags
interface uart_rx_if;
    logic       baud_pulse;
    logic       rx;
    logic       pen;
    logic       eps;
    logic       sticky_parity;
    logic [1:0] wls;
    logic       push;
    logic [7:0] rx_out;
    logic       pe;
    logic       fe;
    logic       bi;
    modport master (output baud_pulse, rx, pen, eps, sticky_parity, wls, input push, rx_out, pe, fe, bi);
    modport slave (input baud_pulse, rx, pen, eps, sticky_parity, wls, output push, rx_out, pe, fe, bi);
endinterface

// File: rtl/uart_rx_top.sv
// uart_rx_top: 16x-oversampled 5..8 bit serial receiver producing a one-clock push with PE/FE/BI per character
module uart_rx_top (
    input  logic        clk,
    input  logic        rst,
    uart_rx_if.slave    bus
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t     state_q, state_d;
    logic       rx_m_q, rx_m_d, rx_s_q, rx_s_d;
    logic       armed_q, armed_d, pbit_q, pbit_d;
    logic [3:0] count_q, count_d;
    logic [2:0] bitcnt_q, bitcnt_d, idx_q, idx_d;
    logic [7:0] data_q, data_d, rx_out_q, rx_out_d;
    logic       push_q, push_d, pe_q, pe_d, fe_q, fe_d, bi_q, bi_d;
    logic       mid, par_err;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rx_m_q   <= 1'b1;
            rx_s_q   <= 1'b1;
            armed_q  <= 1'b0;
            pbit_q   <= 1'b0;
            count_q  <= 4'd0;
            bitcnt_q <= 3'd0;
            idx_q    <= 3'd0;
            data_q   <= 8'd0;
            rx_out_q <= 8'd0;
            push_q   <= 1'b0;
            pe_q     <= 1'b0;
            fe_q     <= 1'b0;
            bi_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            rx_m_q   <= rx_m_d;
            rx_s_q   <= rx_s_d;
            armed_q  <= armed_d;
            pbit_q   <= pbit_d;
            count_q  <= count_d;
            bitcnt_q <= bitcnt_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            rx_out_q <= rx_out_d;
            push_q   <= push_d;
            pe_q     <= pe_d;
            fe_q     <= fe_d;
            bi_q     <= bi_d;
        end
    end
    always_comb begin
        state_d  = state_q;
        rx_m_d   = bus.rx;
        rx_s_d   = rx_m_q;
        armed_d  = armed_q;
        pbit_d   = pbit_q;
        count_d  = count_q;
        bitcnt_d = bitcnt_q;
        idx_d    = idx_q;
        data_d   = data_q;
        rx_out_d = rx_out_q;
        push_d   = 1'b0;
        pe_d     = pe_q;
        fe_d     = fe_q;
        bi_d     = bi_q;
        mid      = bus.baud_pulse && count_q == 4'd0;
        // unused data MSBs are kept 0, so the full-byte XOR covers only the wls-selected bits
        par_err  = bus.pen & (bus.sticky_parity ? (bus.eps ? pbit_q : ~pbit_q)
                                                : (bus.eps ? (^data_q ^ pbit_q) : ~(^data_q ^ pbit_q)));
        if (bus.baud_pulse && state_q != IDLE && count_q != 4'd0)
            count_d = count_q - 4'd1;
        case (state_q)
            IDLE: if (bus.baud_pulse) begin
                if (armed_q && !rx_s_q) begin
                    armed_d = 1'b0;
                    count_d = 4'd7;
                    state_d = START;
                end else if (rx_s_q) armed_d = 1'b1;
            end
            START: if (mid) begin
                if (!rx_s_q) begin
                    count_d  = 4'd15;
                    bitcnt_d = {1'b0, bus.wls} + 3'd4;
                    idx_d    = 3'd0;
                    data_d   = 8'd0;
                    state_d  = DATA;
                end else state_d = IDLE;
            end
            DATA: if (mid) begin
                data_d[idx_q] = rx_s_q;
                count_d = 4'd15;
                idx_d   = idx_q + 3'd1;
                if (idx_q == bitcnt_q) state_d = bus.pen ? PARITY : STOP;
            end
            PARITY: if (mid) begin
                pbit_d  = rx_s_q;
                count_d = 4'd15;
                state_d = STOP;
            end
            STOP: if (mid) begin
                rx_out_d = data_q;
                pe_d     = par_err;
                fe_d     = ~rx_s_q;
                bi_d     = (data_q == 8'd0) & (~bus.pen | ~pbit_q) & ~rx_s_q;
                push_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        bus.push   = push_q;
        bus.rx_out = rx_out_q;
        bus.pe     = pe_q;
        bus.fe     = fe_q;
        bus.bi     = bi_q;
    end
endmodule

// File: tb/tb_uart_rx_top.sv
// tb_uart_rx_top: directed frames on rx with baud_pulse every 4 clocks; expected characters and flags are hand-computed
module tb_uart_rx_top;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   pulse_cnt = 0;
    int   push_cnt = 0;
    int   dbl_push = 0;
    logic push_prev = 1'b0;
    int   div = 0;
    int   p0;
    uart_rx_if bus ();
    uart_rx_top dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(negedge clk) begin
        div = (div == 3) ? 0 : div + 1;
        bus.baud_pulse = (div == 0);
    end
    always @(posedge clk) begin
        if (bus.baud_pulse === 1'b1) pulse_cnt <= pulse_cnt + 1;
        if (bus.push === 1'b1) push_cnt <= push_cnt + 1;
        if (bus.push === 1'b1 && push_prev) dbl_push <= dbl_push + 1;
        push_prev <= (bus.push === 1'b1);
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic wait_pulses(input int n);
        int t;
        t = pulse_cnt + n;
        while (pulse_cnt < t) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic cfg(input logic [1:0] w, input logic p, input logic e, input logic s);
        bus.wls = w;
        bus.pen = p;
        bus.eps = e;
        bus.sticky_parity = s;
    endtask
    task automatic send_frame(input logic [7:0] d, input logic pb, input logic stp);
        bus.rx = 1'b0;
        wait_pulses(16);
        for (int i = 0; i < int'(bus.wls) + 5; i++) begin
            bus.rx = d[i];
            wait_pulses(16);
        end
        if (bus.pen) begin
            bus.rx = pb;
            wait_pulses(16);
        end
        bus.rx = stp;
        wait_pulses(16);
        bus.rx = 1'b1;
        wait_pulses(8);
    endtask
    task automatic rx_check(input string tag, input int base, input logic [7:0] d,
                            input logic pe, input logic fe, input logic bi);
        chk({tag, "_pushes"}, 32'(push_cnt - base), 32'd1);
        chk({tag, "_data"}, 32'(bus.rx_out), 32'(d));
        chk({tag, "_pe"}, 32'(bus.pe), 32'(pe));
        chk({tag, "_fe"}, 32'(bus.fe), 32'(fe));
        chk({tag, "_bi"}, 32'(bus.bi), 32'(bi));
    endtask
    initial begin
        bus.rx = 1'b1;
        cfg(2'b11, 1'b0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("rst_push", 32'(bus.push), 32'd0);
        chk("rst_data", 32'(bus.rx_out), 32'd0);
        chk("rst_pe", 32'(bus.pe), 32'd0);
        chk("rst_fe", 32'(bus.fe), 32'd0);
        chk("rst_bi", 32'(bus.bi), 32'd0);
        rst = 1'b0;
        wait_pulses(4);
        // T1: 8N1 clean frame
        p0 = push_cnt; send_frame(8'hA5, 1'b0, 1'b1); rx_check("t1", p0, 8'hA5, 0, 0, 0);
        // T2: 7E1, 0x35 has even weight so the correct parity bit is 0
        cfg(2'b10, 1'b1, 1'b1, 1'b0);
        p0 = push_cnt; send_frame(8'h35, 1'b1, 1'b1); rx_check("t2_bad", p0, 8'h35, 1, 0, 0);
        p0 = push_cnt; send_frame(8'h35, 1'b0, 1'b1); rx_check("t2_ok", p0, 8'h35, 0, 0, 0);
        cfg(2'b10, 1'b1, 1'b0, 1'b0);
        p0 = push_cnt; send_frame(8'h35, 1'b1, 1'b1); rx_check("odd_ok", p0, 8'h35, 0, 0, 0);
        cfg(2'b10, 1'b1, 1'b0, 1'b1);
        p0 = push_cnt; send_frame(8'h35, 1'b0, 1'b1); rx_check("stick1_bad", p0, 8'h35, 1, 0, 0);
        cfg(2'b10, 1'b1, 1'b1, 1'b1);
        p0 = push_cnt; send_frame(8'h35, 1'b1, 1'b1); rx_check("stick0_bad", p0, 8'h35, 1, 0, 0);
        // T3: 5N1 with a low stop bit, then a clean frame
        cfg(2'b00, 1'b0, 1'b0, 1'b0);
        p0 = push_cnt; send_frame(8'h1F, 1'b0, 1'b0); rx_check("t3_fe", p0, 8'h1F, 0, 1, 0);
        p0 = push_cnt; send_frame(8'h0A, 1'b0, 1'b1); rx_check("t3_ok", p0, 8'h0A, 0, 0, 0);
        // T4: break held for three frame times yields a single character
        cfg(2'b11, 1'b0, 1'b0, 1'b0);
        p0 = push_cnt;
        bus.rx = 1'b0;
        wait_pulses(480);
        rx_check("t4_brk", p0, 8'h00, 0, 1, 1);
        bus.rx = 1'b1;
        wait_pulses(16);
        p0 = push_cnt; send_frame(8'h55, 1'b0, 1'b1); rx_check("t4_ok", p0, 8'h55, 0, 0, 0);
        // T5: glitch shorter than half a bit
        p0 = push_cnt;
        bus.rx = 1'b0;
        wait_pulses(5);
        bus.rx = 1'b1;
        wait_pulses(32);
        chk("t5_nopush", 32'(push_cnt - p0), 32'd0);
        p0 = push_cnt; send_frame(8'hC3, 1'b0, 1'b1); rx_check("t5_ok", p0, 8'hC3, 0, 0, 0);
        // T6: reset in the middle of data bit 3
        p0 = push_cnt;
        bus.rx = 1'b0;
        wait_pulses(16);
        bus.rx = 1'b1;
        wait_pulses(56);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_pulses(100);
        chk("t6_nopush", 32'(push_cnt - p0), 32'd0);
        chk("t6_data", 32'(bus.rx_out), 32'd0);
        chk("t6_pe", 32'(bus.pe), 32'd0);
        chk("t6_fe", 32'(bus.fe), 32'd0);
        chk("t6_bi", 32'(bus.bi), 32'd0);
        p0 = push_cnt; send_frame(8'h81, 1'b0, 1'b1); rx_check("t6_ok", p0, 8'h81, 0, 0, 0);
        chk("push_width", 32'(dbl_push), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
